// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module : clock_set_controller
// Brief  : HH:MM time-set sequencer for the DigitalClock counter chain.
//          Define AUTO_REPEAT_EN to enable auto-repeat while inc is held.
// Rev    : 1.0  initial release
// ============================================================================
module clock_set_controller #(
  parameter int BLINK_HALF_CYCLES   = 25000000,
  parameter int TIMEOUT_CYCLES      = 500000000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  output logic       run_en,
  output logic       load,
  output logic [3:0] load_hour_tens,
  output logic [3:0] load_hour_ones,
  output logic [3:0] load_min_tens,
  output logic [3:0] load_min_ones,
  output logic       blink_hour,
  output logic       blink_min,
  output logic       setting
);

  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         hour_tens_q, hour_tens_d;
  logic [3:0]         hour_ones_q, hour_ones_d;
  logic [3:0]         min_tens_q, min_tens_d;
  logic [3:0]         min_ones_q, min_ones_d;
  logic               mode_prev_q, inc_prev_q;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  logic mode_press;
  logic inc_press_raw;
  logic inc_press;
  logic in_set;
  logic timeout_hit;

  assign mode_press    = btn_mode & ~mode_prev_q;
  assign inc_press_raw = btn_inc & ~inc_prev_q;
  assign in_set        = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
  assign timeout_hit   = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Hour and minute BCD increments; out-of-range values fold back to 00.
  function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if ((t >= 4'd2 && o >= 4'd3) || t > 4'd2) r = 8'h00;
    else if (o >= 4'd9)                       r = {t + 4'd1, 4'd0};
    else                                      r = {t, o + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o >= 4'd9) r = (t >= 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
    else           r = {t, o + 4'd1};
    return r;
  endfunction

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic             rpt_fire;

  // Counts cycles since the press (or last repeat); first fire after the
  // delay, then every rate interval until release.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    if (in_set && btn_inc) begin
      if (rpt_cnt_q == (rpt_armed_q ? RPT_W'(REPEAT_RATE_CYCLES)
                                    : RPT_W'(REPEAT_DELAY_CYCLES))) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = RPT_W'(1);
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
        rpt_armed_d = rpt_armed_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  assign inc_press = inc_press_raw | rpt_fire;
`else
  assign inc_press = inc_press_raw;
`endif

  always_comb begin
    state_d     = state_q;
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;

    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d     = ST_SET_HOUR;
          hour_tens_d = cur_hour_tens;
          hour_ones_d = cur_hour_ones;
          min_tens_d  = cur_min_tens;
          min_ones_d  = cur_min_ones;
        end
      end
      ST_SET_HOUR: begin
        // Mode beats a coincident inc; any press beats the timeout.
        if (mode_press)       state_d = ST_SET_MIN;
        else if (inc_press)   {hour_tens_d, hour_ones_d} = hour_inc(hour_tens_q, hour_ones_q);
        else if (timeout_hit) state_d = ST_RUN;
      end
      ST_SET_MIN: begin
        if (mode_press)       state_d = ST_COMMIT;
        else if (inc_press)   {min_tens_d, min_ones_d} = min_inc(min_tens_q, min_ones_q);
        else if (timeout_hit) state_d = ST_RUN;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    idle_d      = idle_q + IDLE_W'(1);
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;

    if (!in_set || (state_d != state_q) || mode_press || inc_press)
      idle_d = '0;

    // Blink phase restarts visible on every state change and every inc.
    if (!in_set || (state_d != state_q) || inc_press) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      hour_tens_q <= 4'd0;
      hour_ones_q <= 4'd0;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_tens_q <= hour_tens_d;
      hour_ones_q <= hour_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign run_en         = (state_q == ST_RUN);
  assign load           = (state_q == ST_COMMIT);
  assign setting        = in_set;
  assign blink_hour     = (state_q == ST_SET_HOUR) & phase_q;
  assign blink_min      = (state_q == ST_SET_MIN) & phase_q;
  assign load_hour_tens = hour_tens_q;
  assign load_hour_ones = hour_ones_q;
  assign load_min_tens  = min_tens_q;
  assign load_min_ones  = min_ones_q;

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-set sequencer for the DigitalClock counter chain.
- Two user buttons, mode and inc, step through hour/minute editing on shadow registers while the clock is paused.
- On commit, a one-cycle load pulse writes HH:MM:00 into the clock.
- Drives run enable, load value and digit-blink indicators for the display path; same 50 MHz clock domain as the clock.

Parameters:
- BLINK_HALF_CYCLES, 25000000, cycles per blink half-period (0.5 s at 50 MHz).
- TIMEOUT_CYCLES, 500000000, idle cycles in a set state before abort (10 s).
- REPEAT_DELAY_CYCLES, 25000000, inc hold time before first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_RATE_CYCLES, 5000000, auto-repeat interval (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_mode  in  1  mode button level; already synchronized/debounced, active-high.
- btn_inc  in  1  increment button level; already synchronized/debounced, active-high.
- cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones  in  4 each  live BCD time from the clock.
- run_en  out  1  1 = clock counts; 0 = clock paused.
- load  out  1  one-cycle pulse: clock loads load_* digits and clears seconds.
- load_hour_tens, load_hour_ones, load_min_tens, load_min_ones  out  4 each  shadow BCD value; always driven, sampled only when load=1.
- blink_hour  out  1  1 = blank hour digits this cycle.
- blink_min  out  1  1 = blank minute digits this cycle.
- setting  out  1  1 while in SET_HOUR or SET_MIN.

Behaviour:
- Reset (reset=0, async) values:
  - state RUN, run_en=1, load=0, setting=0, blink_hour=0, blink_min=0.
  - Shadow registers 00:00; button history regs 0; all counters 0.
- Press detection: press = level & ~registered previous level. Holding a button produces exactly one press.
- States:
  - RUN:
    - run_en=1.
    - mode press: copy cur_* into shadow, go to SET_HOUR, run_en=0 from the next cycle.
    - inc press ignored.
  - SET_HOUR:
    - inc press: hours +1 in BCD, 00..23; 23 wraps to 00; ones 9 carries into tens.
    - mode press: go to SET_MIN.
  - SET_MIN:
    - inc press: minutes +1 in BCD, 00..59; 59 wraps to 00; no carry into hours.
    - mode press: go to COMMIT.
  - COMMIT:
    - Exactly one cycle: load=1, run_en=0.
    - Next cycle: state RUN, run_en=1, load=0.
    - Clock restarts from HH:MM:00.
- Simultaneous mode and inc press in the same cycle: mode wins; inc is discarded.
- Timeout:
  - Idle counter clears on entering a set state and on any press.
  - Increments each cycle while in SET_HOUR or SET_MIN.
  - On reaching TIMEOUT_CYCLES-1: go to RUN with no load pulse; shadow edits discarded; clock resumes from its paused value.
- Blink:
  - Phase counter restarts on every state change; phase starts visible (blank=0).
  - Phase toggles every BLINK_HALF_CYCLES cycles.
  - blink_hour = (state==SET_HOUR) & phase.
  - blink_min = (state==SET_MIN) & phase.
  - Both 0 in RUN and COMMIT.
  - An inc press resets phase to visible.
- Reset asserted mid-edit: immediate return to reset values; no load.
- Cur_* inputs are sampled only on the RUN->SET_HOUR transition.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - In a set state, inc held for REPEAT_DELAY_CYCLES generates a synthetic press.
  - Further synthetic presses follow every REPEAT_RATE_CYCLES while held.
  - Release clears the repeat counter.
  - Synthetic presses reset the idle timeout like real presses.
- Undefined: no repeat logic synthesized; holding inc yields one increment.

Test Plan:
- Test parameters: BLINK_HALF_CYCLES=4, TIMEOUT_CYCLES=100, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
- Reset and hold: hold reset=0 for 3 cycles with buttons toggling -> run_en=1, load=0, setting=0, blinks 0, load_* = 00:00 throughout.
- Full set flow: cur=12:34; press mode, inc x2, mode, inc x30, mode -> exactly one cycle with load=1 and load_*=14:04; run_en=0 from the first mode until the cycle after load; run_en=1 after.
- Wrap boundaries: cur=23:59; mode, inc once, mode, inc once, mode -> load_* = 00:00, single load pulse.
- Timeout: mode from cur=08:15, inc x3, then idle 100 cycles -> back to RUN, run_en=1, load never asserted, setting=0.
- Collision and blink: in SET_HOUR, assert mode and inc rising edges in the same cycle -> state SET_MIN, hour unchanged; blink_min pattern 0000 1111 0000 with blink_hour=0.
- AUTO_REPEAT_EN defined: in SET_MIN at 00, hold inc 20 cycles -> minutes read 04 (1 edge + repeats at hold cycles 10, 13, 16 -> 04 at cycle 19); undefined -> 01.
